// File: rtl/addsub_pkg.sv
// Shared types for the serial adder/subtractor: FSM state encoding and mode constants.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// Combinational STEP-bit ripple of full-adder / full-subtractor cells selected by mode.
// c_msb is the carry/borrow entering the slice MSB, used for signed-overflow detection.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic            mode,
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  output logic [STEP-1:0] s,
  output logic            cout,
  output logic            c_msb
);

  logic [STEP:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < STEP; i++) begin
      s[i] = a[i] ^ b[i] ^ c[i];
      if (mode == MODE_SUB) begin
        c[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c[i]);
      end else begin
        c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
    end
  end

  assign cout  = c[STEP];
  assign c_msb = c[STEP-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, STEP bits per clock over WIDTH-bit operands.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
// Handshake: start is accepted on an edge where ready=1; done pulses for one
// cycle when result/cout/ovf update; start while busy=1 is dropped.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] wa, wb, wr, wr_nxt, res_q, res_fin;
  logic             carry, mode_q, cout_q, ovf_q;
  logic [CW-1:0]    cnt;
  logic [STEP-1:0]  s_slice;
  logic             co_slice, cm_slice;
  logic             accept, last, ovf_fin;
`ifdef SERIAL_ADDSUB_SAT_EN
  logic             a_msb;
`endif

  addsub_slice #(.STEP(STEP)) u_slice (
    .mode  (mode_q),
    .a     (wa[STEP-1:0]),
    .b     (wb[STEP-1:0]),
    .cin   (carry),
    .s     (s_slice),
    .cout  (co_slice),
    .c_msb (cm_slice)
  );

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));
  // Carry-in vs carry-out of the MSB cell differ exactly on signed overflow (add and sub alike).
  assign ovf_fin = cm_slice ^ co_slice;

  always_comb begin
    wr_nxt                  = wr >> STEP;
    wr_nxt[WIDTH-1 -: STEP] = s_slice;
  end

  always_comb begin
    res_fin = wr_nxt;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_fin) begin
      res_fin = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wa     <= '0;
      wb     <= '0;
      wr     <= '0;
      carry  <= 1'b0;
      mode_q <= MODE_ADD;
      cnt    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
      a_msb  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        wa     <= a;
        wb     <= b;
        carry  <= cin;
        mode_q <= mode;
        cnt    <= '0;
`ifdef SERIAL_ADDSUB_SAT_EN
        a_msb  <= a[WIDTH-1];
`endif
      end else if (state == RUN) begin
        wa    <= wa >> STEP;
        wb    <= wb >> STEP;
        carry <= co_slice;
        wr    <= wr_nxt;
        cnt   <= cnt + 1'b1;
        if (last) begin
          res_q  <= res_fin;
          cout_q <= co_slice;
          ovf_q  <= ovf_fin;
        end
      end
    end
  end

  assign ready  = (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed vector table, randomized ops
// against an arithmetic reference model, handshake/reset sequences, STEP=4/8 instances.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst, start, mode, cin;
  logic [7:0] a, b;

  logic       ready1, busy1, done1, cout1, ovf1;
  logic [7:0] result1;
  logic       ready4, busy4, done4, cout4, ovf4;
  logic [7:0] result4;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] result8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready1), .busy(busy1), .done(done1), .result(result1), .cout(cout1), .ovf(ovf1));

  serial_addsub #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready4), .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4));

  serial_addsub #(.WIDTH(8), .STEP(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .ready(ready8), .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8));

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic logic [9:0] ref_op(input logic m, input logic [7:0] x, input logic [7:0] y,
                                        input logic ci);
    int ux, uy, sx, sy, c, u, s;
    logic [7:0] r;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    c  = ci ? 1 : 0;
    if (m == 1'b0) begin
      u  = ux + uy + c;
      s  = sx + sy + c;
      co = (u > 255);
    end else begin
      u  = ux - uy - c;
      s  = sx - sy - c;
      co = (u < 0);
    end
    r  = u[7:0];
    ov = (s > 127) || (s < -128);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ov) r = (sx < 0) ? 8'h80 : 8'h7F;
`endif
    return {r, co, ov};
  endfunction

  task automatic run_op(input logic m, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, output int lat);
    @(posedge clk); #1;
    mode = m; a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (!done1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  ready1,  1);
    check({tag, "_busy"},   busy1,   0);
    check({tag, "_done"},   done1,   0);
    check({tag, "_result"}, result1, 0);
    check({tag, "_cout"},   cout1,   0);
    check({tag, "_ovf"},    ovf1,    0);
  endtask

  initial begin
    int lat, lat4, lat8;
    logic [9:0] exp;
    logic       rm, rc;
    logic [7:0] ra, rb;

    rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    vecs[0] = '{1'b0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
`ifdef SERIAL_ADDSUB_SAT_EN
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
`else
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
`endif
    vecs[5] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_result", i), result1, vecs[i].res);
      check($sformatf("vec%0d_cout", i), cout1, vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), ovf1, vecs[i].ovf);
      check($sformatf("vec%0d_ready_at_done", i), ready1, 1);
    end

    for (int i = 0; i < 40; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      exp = ref_op(rm, ra, rb, rc);
      run_op(rm, ra, rb, rc, lat);
      check($sformatf("rnd%0d_latency", i), lat, 8);
      check($sformatf("rnd%0d_result", i), result1, exp[9:2]);
      check($sformatf("rnd%0d_cout", i), cout1, exp[1]);
      check($sformatf("rnd%0d_ovf", i), ovf1, exp[0]);
    end

    // start pulsed mid-RUN must be ignored
    @(posedge clk); #1;
    mode = 1'b0; a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (3) @(posedge clk);
    #1;
    mode = 1'b1; a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 4;
    check("ignore_busy", busy1, 1);
    while (!done1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_latency", lat, 8);
    check("ignore_result", result1, 8'h30);

    // back-to-back accept during the DONE cycle
    mode = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    check("b2b_busy", busy1, 1);
    check("b2b_held_early", result1, 8'h30);
    repeat (4) @(posedge clk);
    #1;
    lat = 4;
    check("b2b_held_mid", result1, 8'h30);
    while (!done1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency", lat, 8);
    check("b2b_result", result1, 8'h47);

    // synchronous reset in the middle of RUN
    @(posedge clk); #1;
    mode = 1'b0; a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", done1, 0);
    check("midrst_result_kept", result1, 0);
    run_op(1'b0, 8'h01, 8'h01, 1'b0, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_result", result1, 8'h02);

    // STEP=4 and STEP=8 instances on 0xFF + 0x01
    @(posedge clk); #1;
    mode = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat4 = -1; lat8 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done4 && lat4 < 0) lat4 = i;
      if (done8 && lat8 < 0) lat8 = i;
    end
    check("step4_latency", lat4, 2);
    check("step4_result", result4, 8'h00);
    check("step4_cout", cout4, 1);
    check("step4_ovf", ovf4, 0);
    check("step8_latency", lat8, 1);
    check("step8_result", result8, 8'h00);
    check("step8_cout", cout8, 1);
    check("step8_ovf", ovf8, 0);
    check("step1_result", result1, 8'h00);
    check("step1_cout", cout1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-cycle adder/subtractor that processes STEP bits per clock on WIDTH-bit operands.
- Each slice is built from full-adder/full-subtractor cells; carry or borrow is kept in a register between slices.
- Uses a start/ready/done handshake.
- Replaces the single-bit combinational half/full subtractor cells as the arithmetic datapath for wider operands.

Parameters:
WIDTH, 8, operand/result width in bits; >= 2
STEP, 1, bits processed per cycle; must divide WIDTH; STEP=WIDTH gives a 1-cycle op

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted when ready=1 at a clk edge
mode  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin, cin is borrow-in)
a  input  WIDTH  minuend/augend, sampled on accept
b  input  WIDTH  subtrahend/addend, sampled on accept
cin  input  1  carry-in or borrow-in, sampled on accept
ready  output  1  can accept start
busy  output  1  operation in progress
done  output  1  one-cycle pulse, results valid
result  output  WIDTH  sum/difference, held until the next completion
cout  output  1  carry-out (add) or borrow-out (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high.
  - rst=1 at an edge, including mid-operation: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, ovf=0. The in-flight op is discarded.
- FSM states:
  - IDLE: ready=1, busy=0.
  - RUN: ready=0, busy=1.
  - DONE: ready=1, busy=0, done=1.
- Transitions:
  - IDLE + start: latch a, b, mode and cin into working registers; clear step counter; go to RUN.
  - RUN: each cycle, consume the STEP LSBs of the working a/b and update the carry/borrow register. Shift the STEP result bits in from the MSB side of the working result register.
  - RUN, after N=WIDTH/STEP cycles: write result, cout and ovf to the output registers; go to DONE.
  - DONE, start=0: go to IDLE.
  - DONE, start=1: accept a new op and go to RUN (back-to-back). Outputs stay stable throughout that RUN.
- Latency: start accepted at edge E0 gives done=1 in the cycle after edge E0+N. Throughput is one op per N+1 cycles.
- start while busy=1 is ignored; no queuing.
- result, cout and ovf change only at the completion edge or on rst.
- Bit arithmetic:
  - Add: s = ai^bi^ci; co = ai&bi | ci&(ai^bi).
  - Sub: d = ai^bi^ci; bo = ~ai&bi | ~(ai^bi)&ci.
- cout is the final carry/borrow out of bit WIDTH-1 (unsigned carry or borrow).
- ovf uses the MSBs of the latched operands and the raw result r:
  - Add: a[W-1]==b[W-1] && r[W-1]!=a[W-1].
  - Sub: a[W-1]!=b[W-1] && r[W-1]!=a[W-1].

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf=1, result saturates to signed max (0x7F..F) if a[W-1]=0, else signed min (0x80..0). ovf and cout still report the raw condition.
- Undefined: result is the raw wrapped value. Latency is identical either way.

Decomposition:
- Package addsub_pkg holds:
  - FSM state enum (IDLE, RUN, DONE).
  - Mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module addsub_slice (combinational):
  - STEP-bit ripple of per-bit add/sub cells, selected by mode.
  - Inputs: a slice, b slice, cin. Outputs: result slice, cout, and carry into its MSB.
  - Instantiated once in the top.

Test Plan:
- WIDTH=8, STEP=1, add a=0x3C b=0x05 cin=0 -> result=0x41, cout=0, ovf=0; done exactly 9 cycles after the accepting edge's cycle (N=8 RUN cycles + DONE).
- Sub a=0x05 b=0x07 cin=0 -> result=0xFE, cout=1 (borrow), ovf=0. Sub a=0x00 b=0x00 cin=1 -> result=0xFF, cout=1.
- Overflow: add 0x7F+0x01 -> ovf=1, cout=0; result=0x80 without SERIAL_ADDSUB_SAT_EN, 0x7F with it. Sub 0x80-0x01 -> ovf=1, cout=0; result=0x7F raw, 0x80 saturated.
- Handshake: pulse start again 3 cycles into RUN -> ignored, first result unchanged. Assert start with new operands during the DONE cycle -> accepted, busy=1 next cycle, second result correct.
- rst=1 held one cycle at RUN cycle 4 -> next edge: ready=1, busy=0, done=0, result=0x00, cout=0, ovf=0. A following add 0x01+0x01 -> 0x02.
- WIDTH=8, STEP=4: 0xFF+0x01 cin=0 -> result=0x00, cout=1, ovf=0, done 2 cycles after accept. STEP=8: same op completes in 1 RUN cycle.
